inpass_sync_frame_config: RTL and testbench
===========================================

# inpass_sync_frame_config

Parametrised input-pass BEL for RAM_IO-style tiles that carries NUM_CH external input pins into the fabric switch matrix. Each channel is individually configured from frame config bits for combinational pass-through, single-register capture, multi-flop synchronisation, or synchronised rising-edge pulse generation. It generalises the fixed 4-channel comb/registered input pass to any width. It also makes asynchronous pad inputs safe to consume in UserCLK logic.

## Interface
- NUM_CH, 4: number of independent input channels, 1..32
- SYNC_STAGES, 2: flop depth of the synchroniser chain, ≥2
- NoConfigBits, 2*NUM_CH: frame config bits consumed; must equal 2*NUM_CH

Ports:
- UserCLK  input  1  fabric user clock; shared port, exported to top
- UserRST_N  input  1  asynchronous, active-low reset; clears all flops
- I  input  NUM_CH  external pad inputs; EXTERNAL, may be asynchronous to UserCLK
- O  output  NUM_CH  channel outputs into the switch matrix
- ConfigBits  input  NoConfigBits  GLOBAL frame config; bits [2i+1:2i] = mode of channel i

## Operation
Mode encoding per channel:
- 00 COMB: O[i] = I[i], no register
- 01 REG: O[i] = single flop of I[i]
- 10 SYNC: O[i] = last stage of a SYNC_STAGES-deep flop chain on I[i]
- 11 EDGE: O[i] = sync_out & ~sync_prev, where sync_prev is a flop of sync_out
- All flops (reg, sync chain, sync_prev) clock every UserCLK edge regardless of mode.
- A mode change takes effect combinationally through the output mux. No flush and no reset on mode change.
- Reset: every flop is 0. O[i] = I[i] in COMB, 0 in REG/SYNC/EDGE.
- EDGE after reset release with I held high: one pulse after SYNC_STAGES edges, because sync_prev starts at 0.
- EDGE with I toggling every cycle: a pulse every second cycle. It never stays high for two consecutive cycles.
- EDGE holds O low on a falling edge or a steady level.
- Elaboration error if SYNC_STAGES < 2 or NoConfigBits != 2*NUM_CH.

## Timing
- COMB: zero latency.
- REG: I sampled at edge k appears on O after edge k, i.e. 1 cycle.
- SYNC: I sampled at edge k appears on O after edge k+SYNC_STAGES-1, i.e. SYNC_STAGES cycles.
- EDGE: the pulse occupies exactly the first cycle in which SYNC output would be 1. Same latency as SYNC, width 1 cycle.
- Reset assertion clears flops immediately (async). Deassertion is assumed synchronous to UserCLK and is handled upstream.
- Reset mid-operation in EDGE with I high: the pulse repeats once after release.
- REG/SYNC/EDGE outputs are driven purely from flops, so they are glitch-free. COMB is not.

## Configuration
- INPASS_EDGE_DETECT_EN
  - Defined: mode 11 = EDGE as above, and the sync_prev flop is instantiated per channel.
  - Undefined: mode 11 behaves identically to mode 10 (SYNC), and no sync_prev flops exist. The 2-bit config layout is unchanged.

## Structure
- Package inpass_pkg:
  - Mode localparams MODE_COMB=2'b00, MODE_REG=2'b01, MODE_SYNC=2'b10, MODE_EDGE=2'b11.
  - Typedef inpass_mode_t (2-bit).
  - MIN_SYNC_STAGES=2.
- Sub-module inpass_channel: one pad bit, its REG flop, sync chain, edge flop and 4:1 output mux.
  - Output muxing uses my_mux2 cells (two-level tree) so the selector is a library cell, not inferred logic.
- Top generates NUM_CH instances of inpass_channel and slices ConfigBits.
- BelMap attribute lists I<i>_mode0/_mode1 at bits 2i/2i+1.

## Test plan
- Reset: NUM_CH=4, ConfigBits=8'b11_10_01_00, UserRST_N=0, I=4'b1111 -> O=4'b0001. Release reset -> O[1]=1 after 1 edge, O[2]=1 after 2 edges, O[3] high exactly during cycle 2 then 0.
- REG latency: ch0 mode 01, I[0] pattern 1,0,1,1 on successive edges -> O[0] is the same pattern delayed exactly 1 cycle.
- SYNC depth: SYNC_STAGES=3, mode 10, I[0] rises at edge 5 -> O[0] rises after edge 7, never earlier.
- EDGE toggling: mode 11, I toggles every cycle for 10 cycles -> exactly 5 one-cycle pulses, no two adjacent cycles high. With INPASS_EDGE_DETECT_EN undefined -> O equals the SYNC-delayed input.
- Live mode switch: I[0]=1 steady, switch ch0 00→01→10→11 mid-run -> O[0] stays 1 in every mode except 11, where it is 0 (no edge). Flops are not reset.
- Async reset mid-run: assert UserRST_N=0 between edges with SYNC output high -> O drops to 0 without a clock edge. After release, a mode-11 channel with I high gives one pulse.

Source files
------------

// File: rtl/inpass_pkg.sv
// rtl/inpass_pkg.sv - mode encoding and limits for the input-pass BEL
package inpass_pkg;

  typedef logic [1:0] inpass_mode_t;

  localparam inpass_mode_t MODE_COMB = 2'b00;
  localparam inpass_mode_t MODE_REG  = 2'b01;
  localparam inpass_mode_t MODE_SYNC = 2'b10;
  localparam inpass_mode_t MODE_EDGE = 2'b11;

  localparam int MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/inpass_channel.sv
// rtl/inpass_channel.sv - one pad bit: capture flop, sync chain, optional edge flop, 4:1 output tree
// Optional feature macro: INPASS_EDGE_DETECT_EN
module inpass_channel
  import inpass_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         pad_i,
  input  inpass_mode_t mode_i,
  output logic         o_o
);

  logic                   reg_q;
  logic                   reg_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   sync_out;
  logic                   edge_out;
  logic                   low_leg;
  logic                   high_leg;

  assign reg_d    = pad_i;
  assign sync_d   = {sync_q[SYNC_STAGES-2:0], pad_i};
  assign sync_out = sync_q[SYNC_STAGES-1];

  // Every flop runs in every mode so a live mode switch sees settled history.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_q  <= 1'b0;
      sync_q <= '0;
    end else begin
      reg_q  <= reg_d;
      sync_q <= sync_d;
    end
  end

`ifdef INPASS_EDGE_DETECT_EN
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sync_out;
    end
  end

  assign edge_out = sync_out & ~prev_q;
`else
  assign edge_out = sync_out;
`endif

  my_mux2 u_mux_low (
    .a0_i (pad_i),
    .a1_i (reg_q),
    .s_i  (mode_i[0]),
    .x_o  (low_leg)
  );

  my_mux2 u_mux_high (
    .a0_i (sync_out),
    .a1_i (edge_out),
    .s_i  (mode_i[0]),
    .x_o  (high_leg)
  );

  my_mux2 u_mux_out (
    .a0_i (low_leg),
    .a1_i (high_leg),
    .s_i  (mode_i[1]),
    .x_o  (o_o)
  );

endmodule

// File: rtl/my_mux2.sv
// rtl/my_mux2.sv - 2:1 mux library cell used for per-channel output selection
module my_mux2 (
  input  logic a0_i,
  input  logic a1_i,
  input  logic s_i,
  output logic x_o
);

  assign x_o = s_i ? a1_i : a0_i;

endmodule

// File: rtl/inpass_sync_frame_config.sv
// rtl/inpass_sync_frame_config.sv - NUM_CH-wide configurable input pass (comb/reg/sync/edge)
// Optional feature macro: INPASS_EDGE_DETECT_EN. BelMap: I<i>_mode0 = bit 2i, I<i>_mode1 = bit 2i+1.
module inpass_sync_frame_config
  import inpass_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int NoConfigBits = 2 * NUM_CH
) (
  input  logic                    UserCLK,
  input  logic                    UserRST_N,
  input  logic [NUM_CH-1:0]       I,
  output logic [NUM_CH-1:0]       O,
  input  logic [NoConfigBits-1:0] ConfigBits
);

  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync_stages
    $error("inpass_sync_frame_config: SYNC_STAGES must be at least %0d", MIN_SYNC_STAGES);
  end

  if (NoConfigBits != 2 * NUM_CH) begin : g_bad_config_bits
    $error("inpass_sync_frame_config: NoConfigBits must equal 2*NUM_CH");
  end

  if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
    $error("inpass_sync_frame_config: NUM_CH must be in 1..32");
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    inpass_channel #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk_i  (UserCLK),
      .rst_ni (UserRST_N),
      .pad_i  (I[c]),
      .mode_i (ConfigBits[2*c +: 2]),
      .o_o    (O[c])
    );
  end

endmodule

// File: tb/tb_inpass_sync_frame_config.sv
// tb/tb_inpass_sync_frame_config.sv - vector table, scoreboard and corner sequences for the input pass
module tb_inpass_sync_frame_config;

  localparam int SS  = 2;
  localparam int SSB = 3;
`ifdef INPASS_EDGE_DETECT_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rst_b = 1'b0;
  logic [3:0] din = 4'hF;
  logic [3:0] dout;
  logic [7:0] cfg = 8'hE4;
  logic [0:0] din_b = 1'b0;
  logic [0:0] dout_b;
  logic [1:0] cfg_b = 2'b10;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  inpass_sync_frame_config #(.NUM_CH(4), .SYNC_STAGES(SS), .NoConfigBits(8)) dut (
    .UserCLK    (clk),
    .UserRST_N  (rst_n),
    .I          (din),
    .O          (dout),
    .ConfigBits (cfg)
  );

  inpass_sync_frame_config #(.NUM_CH(1), .SYNC_STAGES(SSB), .NoConfigBits(2)) dut_b (
    .UserCLK    (clk),
    .UserRST_N  (rst_b),
    .I          (din_b),
    .O          (dout_b),
    .ConfigBits (cfg_b)
  );

  typedef struct {
    bit         clk_en;
    logic       rst;
    logic [7:0] cfg;
    logic [3:0] i;
    logic [3:0] exp_e;
    logic [3:0] exp_s;
    string      name;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] exp_q[$];
  logic [3:0] hist[0:SS];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input bit ce, input logic r, input logic [7:0] c, input logic [3:0] i,
                     input logic [3:0] ee, input logic [3:0] es, input string nm);
    vec_t v;
    v.clk_en = ce; v.rst = r; v.cfg = c; v.i = i; v.exp_e = ee; v.exp_s = es; v.name = nm;
    vecs.push_back(v);
  endtask

  // Reference: a channel's output is a function of mode and the last SS+1 sampled inputs.
  function automatic logic [3:0] model_out(input logic [7:0] c, input logic [3:0] i);
    logic [3:0] r;
    for (int ch = 0; ch < 4; ch++) begin
      case (c[2*ch +: 2])
        2'b00:   r[ch] = i[ch];
        2'b01:   r[ch] = hist[0][ch];
        2'b10:   r[ch] = hist[SS-1][ch];
        default: r[ch] = EDGE_EN ? (hist[SS-1][ch] & ~hist[SS][ch]) : hist[SS-1][ch];
      endcase
    end
    return r;
  endfunction

  initial begin
    logic       o, prev_o, samp_prev;
    int         pulses;
    logic [3:0] got;

    add(1, 0, 8'hE4, 4'hF, 4'b0001, 4'b0001, "reset_hold");
    add(1, 1, 8'hE4, 4'hF, 4'b0011, 4'b0011, "release_e1");
    add(1, 1, 8'hE4, 4'hF, 4'b1111, 4'b1111, "release_e2");
    add(1, 1, 8'hE4, 4'hF, 4'b0111, 4'b1111, "release_e3");
    add(1, 1, 8'hE4, 4'hF, 4'b0111, 4'b1111, "steady_high");
    add(1, 1, 8'h01, 4'b0001, 4'b0001, 4'b0001, "reg_p0");
    add(0, 1, 8'h01, 4'b0000, 4'b0001, 4'b0001, "reg_hold0");
    add(1, 1, 8'h01, 4'b0000, 4'b0000, 4'b0000, "reg_p1");
    add(0, 1, 8'h01, 4'b0001, 4'b0000, 4'b0000, "reg_hold1");
    add(1, 1, 8'h01, 4'b0001, 4'b0001, 4'b0001, "reg_p2");
    add(1, 1, 8'h01, 4'b0001, 4'b0001, 4'b0001, "reg_p3");
    add(1, 1, 8'h01, 4'b0001, 4'b0001, 4'b0001, "reg_settle");
    add(0, 1, 8'h00, 4'b0001, 4'b0001, 4'b0001, "live_comb");
    add(0, 1, 8'h01, 4'b0001, 4'b0001, 4'b0001, "live_reg");
    add(0, 1, 8'h02, 4'b0001, 4'b0001, 4'b0001, "live_sync");
    add(0, 1, 8'h03, 4'b0001, 4'b0000, 4'b0001, "live_edge");
    add(1, 1, 8'h02, 4'b0001, 4'b0001, 4'b0001, "live_back_sync");

    #1;
    check("reset_comb_immediate", dout, 4'b0001);
    foreach (vecs[k]) begin
      rst_n = vecs[k].rst;
      cfg   = vecs[k].cfg;
      din   = vecs[k].i;
      if (vecs[k].clk_en) tick();
      else #1;
      check(vecs[k].name, dout, EDGE_EN ? vecs[k].exp_e : vecs[k].exp_s);
    end

    // Toggle ch0 in mode 11 from a settled-high history.
    cfg = 8'h03;
    prev_o = dout[0];
    samp_prev = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      din = {3'b000, (k < 10) ? logic'(k % 2) : 1'b0};
      tick();
      o = dout[0];
`ifdef INPASS_EDGE_DETECT_EN
      check("edge_no_adjacent", {3'b000, o & prev_o}, 4'b0000);
      if (o) pulses++;
`else
      check("edge_off_is_sync", {3'b000, o}, {3'b000, samp_prev});
`endif
      samp_prev = din[0];
      prev_o = o;
    end
`ifdef INPASS_EDGE_DETECT_EN
    check("edge_pulse_count", pulses[3:0], 4'd5);
`endif

    // Async reset while sync outputs are high.
    cfg = 8'b11_10_10_00;
    din = 4'hF;
    tick(); tick(); tick();
    check("pre_async_rst", dout, EDGE_EN ? 4'b0111 : 4'b1111);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_no_clock", dout, 4'b0001);
    tick();
    check("async_rst_held", dout, 4'b0001);
    rst_n = 1'b1;
    tick();
    check("post_rst_e1", dout, 4'b0001);
    tick();
    check("post_rst_e2_pulse", dout, 4'b1111);
    tick();
    check("post_rst_e3", dout, EDGE_EN ? 4'b0111 : 4'b1111);

    // Three-stage synchroniser on the second instance.
    check("sync3_reset", {3'b000, dout_b}, 4'b0000);
    rst_b = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      din_b = (e >= 5) ? 1'b1 : 1'b0;
      tick();
      check($sformatf("sync3_edge%0d", e), {3'b000, dout_b}, {3'b000, logic'(e >= 7)});
    end

    // Randomised scoreboard with live mode changes.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k <= SS; k++) hist[k] = 4'h0;
    for (int n = 0; n < 200; n++) begin
      if (n % 8 == 0) cfg = 8'($urandom);
      din = 4'($urandom);
      for (int k = SS; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = din;
      exp_q.push_back(model_out(cfg, din));
      tick();
      got = dout;
      check($sformatf("scoreboard_%0d", n), got, exp_q.pop_front());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
